ex_mem_stage: RTL and testbench

- Consumer end of the ID/EX interface: takes the operand pair, 4-bit ALU control code and forwarded control fields, executes the operation, and registers the result into the EX/MEM pipeline register.
- Single-cycle ops: add, sub, and, or.
- Multiply (ALU control 4'b1111) is an iterative shift-add unit; it stalls the front of the pipeline until the product is ready.
- Sits between the ID/EX decode logic and the data-memory/write-back stages.

---
 rtl/ex_mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX stage ALU with iterative shift-add multiplier and EX/MEM register
// Revision : 1.0
// ============================================================================
module ex_mem_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [3:0]  alu_ctrl_i,
  input  logic [31:0] simm_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  mem_i,
  input  logic        wb_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] alu_result_o,
  output logic        zero_o,
  output logic [31:0] simm_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  mem_o,
  output logic        wb_o
);

  localparam int         N_ITER     = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [4:0] c_last_cnt = 5'(N_ITER - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_mul = 4'b1111;

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] cap_simm_q, cap_simm_d;
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic [1:0]  cap_mem_q, cap_mem_d;
  logic        cap_wb_q, cap_wb_d;

  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic [31:0] simm_q, simm_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  mem_q, mem_d;
  logic        wb_q, wb_d;

  logic [31:0] w_alu_res;
  logic [31:0] w_partial;
  logic [31:0] w_product;
  logic        w_is_mul;
  logic        w_accept;
  logic        w_last;

  always_comb begin
    w_alu_res = '0;
    case (alu_ctrl_i)
      c_op_add: w_alu_res = val1_i + val2_i;
      c_op_sub: w_alu_res = val1_i - val2_i;
      c_op_and: w_alu_res = val1_i & val2_i;
      c_op_or:  w_alu_res = val1_i | val2_i;
      default:  w_alu_res = '0;
    endcase
  end

  // Sum of this iteration's partial products; upper product bits fall off naturally.
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) begin
        w_partial = w_partial + (mcand_q << k);
      end
    end
  end

  assign w_product = acc_q + w_partial;
  assign w_is_mul  = (alu_ctrl_i == c_op_mul);
  assign w_accept  = (state_q == c_st_idle) && valid_i && w_is_mul;
  assign w_last    = (state_q == c_st_busy) && (cnt_q == c_last_cnt);

  assign stall_o = w_accept || ((state_q == c_st_busy) && (cnt_q != c_last_cnt));
  assign busy_o  = (state_q == c_st_busy);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cap_simm_d = cap_simm_q;
    cap_rd_d   = cap_rd_q;
    cap_mem_d  = cap_mem_q;
    cap_wb_d   = cap_wb_q;

    valid_d  = 1'b0;
    result_d = '0;
    zero_d   = 1'b0;
    simm_d   = '0;
    rd_d     = '0;
    mem_d    = '0;
    wb_d     = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          state_d    = c_st_busy;
          cnt_d      = '0;
          mcand_d    = val1_i;
          mplier_d   = val2_i;
          acc_d      = '0;
          cap_simm_d = simm_i;
          cap_rd_d   = rd_addr_i;
          cap_mem_d  = mem_i;
          cap_wb_d   = wb_i;
        end else if (valid_i) begin
          valid_d  = 1'b1;
          result_d = w_alu_res;
          zero_d   = (w_alu_res == '0);
          simm_d   = simm_i;
          rd_d     = rd_addr_i;
          mem_d    = mem_i;
          wb_d     = wb_i;
        end
      end
      c_st_busy: begin
        acc_d    = w_product;
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (w_last) begin
          state_d  = c_st_idle;
          cnt_d    = '0;
          valid_d  = 1'b1;
          result_d = w_product;
          zero_d   = (w_product == '0);
          simm_d   = cap_simm_q;
          rd_d     = cap_rd_q;
          mem_d    = cap_mem_q;
          wb_d     = cap_wb_q;
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= c_st_idle;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cap_simm_q <= '0;
      cap_rd_q   <= '0;
      cap_mem_q  <= '0;
      cap_wb_q   <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      simm_q     <= '0;
      rd_q       <= '0;
      mem_q      <= '0;
      wb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cap_simm_q <= cap_simm_d;
      cap_rd_q   <= cap_rd_d;
      cap_mem_q  <= cap_mem_d;
      cap_wb_q   <= cap_wb_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      simm_q     <= simm_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

  assign valid_o      = valid_q;
  assign alu_result_o = result_q;
  assign zero_o       = zero_q;
  assign simm_o       = simm_q;
  assign rd_addr_o    = rd_q;
  assign mem_o        = mem_q;
  assign wb_o         = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed bench for ex_mem_stage, multiplier at 1 and 4 bits/cycle
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic [3:0]  ctrl = '0;
  logic [31:0] simm = '0;
  logic [4:0]  rd = '0;
  logic [1:0]  mem = '0;
  logic        wb = 1'b0;

  logic        stall1, busy1, valid1, zero1, wb1;
  logic [31:0] res1, simm1;
  logic [4:0]  rd1;
  logic [1:0]  mem1;

  logic        stall4, busy4, valid4, zero4, wb4;
  logic [31:0] res4, simm4;
  logic [4:0]  rd4;
  logic [1:0]  mem4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .val1_i(val1), .val2_i(val2),
    .alu_ctrl_i(ctrl), .simm_i(simm), .rd_addr_i(rd), .mem_i(mem), .wb_i(wb),
    .stall_o(stall1), .busy_o(busy1), .valid_o(valid1), .alu_result_o(res1),
    .zero_o(zero1), .simm_o(simm1), .rd_addr_o(rd1), .mem_o(mem1), .wb_o(wb1)
  );

  ex_mem_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .val1_i(val1), .val2_i(val2),
    .alu_ctrl_i(ctrl), .simm_i(simm), .rd_addr_i(rd), .mem_i(mem), .wb_i(wb),
    .stall_o(stall4), .busy_o(busy4), .valid_o(valid4), .alu_result_o(res4),
    .zero_o(zero4), .simm_o(simm4), .rd_addr_o(rd4), .mem_o(mem4), .wb_o(wb4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [31:0] s, input logic [4:0] r,
                       input logic [1:0] m, input logic w);
    valid = v; val1 = a; val2 = b; ctrl = c; simm = s; rd = r; mem = m; wb = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_mul(input bit sel4, input int n, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input bit corrupt,
                        input logic [31:0] exp);
    logic [31:0] s;
    s = 32'hC0DE_0000 | 32'(r);
    drive(1'b1, a, b, 4'hF, s, r, 2'b00, 1'b1);
    #1;
    chk("mul_stall_accept", sel4 ? stall4 : stall1, 1);
    tick;
    for (int i = 1; i < n; i++) begin
      chk("mul_bubble", sel4 ? valid4 : valid1, 0);
      chk("mul_busy", sel4 ? busy4 : busy1, 1);
      chk("mul_stall_busy", sel4 ? stall4 : stall1, 1);
      if (corrupt) begin
        val1 = $urandom;
        val2 = $urandom;
        rd   = 5'($urandom);
        simm = $urandom;
      end
      tick;
    end
    chk("mul_bubble_last", sel4 ? valid4 : valid1, 0);
    chk("mul_stall_last", sel4 ? stall4 : stall1, 0);
    tick;
    chk("mul_result", sel4 ? res4 : res1, exp);
    chk("mul_rd", sel4 ? rd4 : rd1, r);
    chk("mul_simm", sel4 ? simm4 : simm1, s);
    chk("mul_valid", sel4 ? valid4 : valid1, 1);
    chk("mul_wb", sel4 ? wb4 : wb1, 1);
    chk("mul_zero", sel4 ? zero4 : zero1, (exp == 0) ? 1 : 0);
    chk("mul_idle", sel4 ? busy4 : busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_valid", valid1, 0);
    chk("rst_result", res1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_stall", stall1, 0);
    chk("rst_valid4", valid4, 0);

    // Single-cycle ops, back-to-back
    drive(1'b1, 32'd7, 32'd5, 4'b0010, 32'h0000_00AA, 5'd3, 2'b01, 1'b1);
    #1;
    chk("add_stall", stall1, 0);
    tick;
    chk("add_result", res1, 32'd12);
    chk("add_valid", valid1, 1);
    chk("add_rd", rd1, 5'd3);
    chk("add_wb", wb1, 1);
    chk("add_mem", mem1, 2'b01);
    chk("add_simm", simm1, 32'h0000_00AA);
    chk("add_zero", zero1, 0);
    drive(1'b1, 32'd3, 32'd5, 4'b0110, 32'h0, 5'd3, 2'b00, 1'b1);
    tick;
    chk("sub_result", res1, 32'hFFFF_FFFE);
    chk("sub_valid", valid1, 1);
    drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h0, 5'd3, 2'b00, 1'b1);
    tick;
    chk("and_result", res1, 32'h00F0_00F0);
    drive(1'b1, 32'd1, 32'd2, 4'b0001, 32'h0, 5'd3, 2'b00, 1'b1);
    tick;
    chk("or_result", res1, 32'd3);
    drive(1'b1, 32'd5, 32'd5, 4'b0110, 32'h0, 5'd3, 2'b00, 1'b1);
    tick;
    chk("sub0_result", res1, 32'd0);
    chk("sub0_zero", zero1, 1);
    drive(1'b1, 32'd9, 32'd4, 4'b0101, 32'h1234_5678, 5'd7, 2'b10, 1'b1);
    tick;
    chk("undef_result", res1, 32'd0);
    chk("undef_rd", rd1, 5'd7);
    chk("undef_mem", mem1, 2'b10);
    chk("undef_simm", simm1, 32'h1234_5678);
    chk("undef_valid", valid1, 1);
    drive(1'b0, 32'd9, 32'd4, 4'b0010, 32'h1234_5678, 5'd7, 2'b11, 1'b1);
    tick;
    chk("bubble_valid", valid1, 0);
    chk("bubble_wb", wb1, 0);
    chk("bubble_mem", mem1, 2'b00);

    // Multiplier, one bit per cycle
    do_mul(1'b0, 32, 32'h0000_1234, 32'h0000_0010, 5'd9, 1'b0, 32'h0001_2340);
    do_mul(1'b0, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, 32'h0000_0001);
    do_mul(1'b0, 32, 32'h8000_0000, 32'h0000_0002, 5'd11, 1'b0, 32'h0000_0000);
    do_mul(1'b0, 32, 32'h0001_0003, 32'h0000_0101, 5'd12, 1'b1, 32'h0101_0303);

    // Back-to-back muls with an add queued behind them
    do_mul(1'b0, 32, 32'd3, 32'd5, 5'd4, 1'b0, 32'd15);
    do_mul(1'b0, 32, 32'h0000_0100, 32'h0000_0100, 5'd5, 1'b0, 32'h0001_0000);
    drive(1'b1, 32'd1, 32'd1, 4'b0010, 32'h0, 5'd6, 2'b00, 1'b1);
    #1;
    chk("b2b_add_stall", stall1, 0);
    tick;
    chk("b2b_add_result", res1, 32'd2);
    chk("b2b_add_rd", rd1, 5'd6);
    chk("b2b_add_valid", valid1, 1);
    drive(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 5'd0, 2'b00, 1'b0);
    tick;

    // Reset in the middle of a multiply at cnt = 10
    drive(1'b1, 32'h0000_1234, 32'h0000_0010, 4'hF, 32'h0000_5555, 5'd9, 2'b01, 1'b1);
    tick;
    repeat (10) tick;
    chk("pre_rst_busy", busy1, 1);
    rst = 1'b1;
    valid = 1'b0;
    tick;
    chk("midrst_valid", valid1, 0);
    chk("midrst_result", res1, 0);
    chk("midrst_zero", zero1, 0);
    chk("midrst_simm", simm1, 0);
    chk("midrst_rd", rd1, 0);
    chk("midrst_mem", mem1, 0);
    chk("midrst_wb", wb1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_stall", stall1, 0);
    chk("midrst_busy4", busy4, 0);
    rst = 1'b0;
    do_mul(1'b0, 32, 32'd6, 32'd7, 5'd2, 1'b0, 32'd42);
    drive(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 5'd0, 2'b00, 1'b0);
    tick;

    // Multiplier, four bits per cycle (dut1 was reset above; restart from idle)
    rst = 1'b1;
    tick;
    rst = 1'b0;
    do_mul(1'b1, 8, 32'h0000_1234, 32'h0000_0010, 5'd9, 1'b0, 32'h0001_2340);
    do_mul(1'b1, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, 32'h0000_0001);
    do_mul(1'b1, 8, 32'h8000_0000, 32'h0000_0002, 5'd11, 1'b0, 32'h0000_0000);
    do_mul(1'b1, 8, 32'h0001_0003, 32'h0000_0101, 5'd12, 1'b1, 32'h0101_0303);
    drive(1'b1, 32'd20, 32'd22, 4'b0010, 32'h0, 5'd8, 2'b00, 1'b1);
    tick;
    chk("b4_add_result", res4, 32'd42);
    chk("b4_add_valid", valid4, 1);
    drive(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 5'd0, 2'b00, 1'b0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
